imm_extend_unit: RTL and testbench

Parametrised, pipelined successor to the combinational immediate extender. Accepts an instruction immediate field plus a 2-bit mode, then produces a DATA_W-bit constant through one registered valid/ready stage. Supports zero-fill, sign-extend and upper-immediate modes, plus a prefix mode that captures high-order bits and combines them with the next immediate. Sits between decode and the ALU operand mux.

---
 rtl/imm_pkg.sv | 15 +
 rtl/imm_extend_core.sv | 59 +++++
 rtl/imm_extend_unit.sv | 95 +++++++++
 tb/tb_imm_extend_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate extender:
// operand modes and prefix state encoding.
package imm_pkg;

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_PREFIX = 2'b11;

  typedef enum logic {
    PFX_IDLE  = 1'b0,
    PFX_ARMED = 1'b1
  } pfx_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational value former: extends an immediate,
// optionally joined with a captured prefix.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int IMM_W  = 15,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [IMM_W-1:0]  pfx,
  input  logic              armed,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] value,
  output logic              prefixed
);

  localparam int CW = 2 * IMM_W;

  logic [DATA_W-1:0] zx;
  logic [DATA_W-1:0] sx;
  logic [DATA_W-1:0] ux;
  logic [DATA_W-1:0] czx;
  logic [DATA_W-1:0] csx;
  logic signed [CW-1:0] cs;

  assign zx = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign sx = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign ux = {imm, {(DATA_W-IMM_W){1'b0}}};

  // Cast keeps this legal when 2*IMM_W == DATA_W
  assign cs  = {pfx, imm};
  assign czx = DATA_W'(unsigned'(cs));
  assign csx = DATA_W'(cs);

  always_comb begin
    value    = '0;
    prefixed = 1'b0;
    unique case (1'b1)
      (mode == MODE_ZERO): begin
        value    = armed ? czx : zx;
        prefixed = armed;
      end
      (mode == MODE_SIGN): begin
        value    = armed ? csx : sx;
        prefixed = armed;
      end
      (mode == MODE_UPPER): begin
        value = ux;
      end
      (mode == MODE_PREFIX): begin
        value = '0;
      end
      default: begin
        value = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate extender with prefix capture,
// sitting between decode and the ALU operand mux.
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter int IMM_W  = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_prefixed,
  output logic              pfx_err
);

  if (IMM_W < 2 || 2 * IMM_W > DATA_W) begin : g_bad_params
    $error("imm_extend_unit: illegal IMM_W/DATA_W");
  end

  pfx_state_t        state_q;
  pfx_state_t        state_d;
  logic [IMM_W-1:0]  pfx_reg;
  logic              accept;
  logic              is_pfx;
  logic [DATA_W-1:0] value;
  logic              prefixed;

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign is_pfx   = (in_mode == MODE_PREFIX);

  imm_extend_core #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W)
  ) u_core (
    .imm     (in_imm),
    .pfx     (pfx_reg),
    .armed   (state_q == PFX_ARMED),
    .mode    (in_mode),
    .value   (value),
    .prefixed(prefixed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PFX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = PFX_IDLE;
    end else if (accept) begin
      state_d = is_pfx ? PFX_ARMED : PFX_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_prefixed <= 1'b0;
      pfx_err      <= 1'b0;
      pfx_reg      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      if (is_pfx) begin
        // A prefix yields no output, so the slot empties
        pfx_reg   <= in_imm;
        out_valid <= 1'b0;
        if (state_q == PFX_ARMED) begin
          pfx_err <= 1'b1;
        end
      end else begin
        out_valid    <= 1'b1;
        out_data     <= value;
        out_prefixed <= prefixed;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: vector table
// plus scoreboard and hand-written corner sequences.
module tb_imm_extend_unit;

  localparam logic [1:0] MZ = 2'b00;
  localparam logic [1:0] MS = 2'b01;
  localparam logic [1:0] MU = 2'b10;
  localparam logic [1:0] MP = 2'b11;

  typedef struct {
    logic [1:0]  mode;
    logic [14:0] imm;
    logic [31:0] data;
    logic        pfx;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        pfx;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_imm;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_prefixed;
  logic        pfx_err;

  int checks;
  int errors;
  int cyc;
  exp_t sb[$];
  int out_cyc[$];
  vec_t vecs[12];

  imm_extend_unit #(
    .IMM_W (15),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_imm      (in_imm),
    .in_mode     (in_mode),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_prefixed(out_prefixed),
    .pfx_err     (pfx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output side of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none",
                 out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_prefixed", 32'(out_prefixed), 32'(e.pfx));
      end
    end
  end

  task automatic send(input logic [1:0] m,
                      input logic [14:0] imm,
                      input logic [31:0] ed,
                      input logic ep);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_mode  = m;
    in_imm   = imm;
    n  = 0;
    ok = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end else if (m != MP) begin
      sb.push_back('{data: ed, pfx: ep});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = MZ;
    flush     = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = '{MZ, 15'h4001, 32'h0000_4001, 1'b0};
    vecs[1]  = '{MS, 15'h4001, 32'hFFFF_C001, 1'b0};
    vecs[2]  = '{MS, 15'h3FFF, 32'h0000_3FFF, 1'b0};
    vecs[3]  = '{MU, 15'h0003, 32'h0006_0000, 1'b0};
    vecs[4]  = '{MP, 15'h4000, 32'h0, 1'b0};
    vecs[5]  = '{MS, 15'h0000, 32'hE000_0000, 1'b1};
    vecs[6]  = '{MP, 15'h0001, 32'h0, 1'b0};
    vecs[7]  = '{MZ, 15'h0002, 32'h0000_8002, 1'b1};
    vecs[8]  = '{MP, 15'h7FFF, 32'h0, 1'b0};
    vecs[9]  = '{MU, 15'h0003, 32'h0006_0000, 1'b0};
    vecs[10] = '{MP, 15'h0001, 32'h0, 1'b0};
    vecs[11] = '{MP, 15'h0002, 32'h0, 1'b0};

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_prefixed", 32'(out_prefixed), 32'd0);
    chk("rst_pfx_err", 32'(pfx_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    foreach (vecs[i]) begin
      send(vecs[i].mode, vecs[i].imm, vecs[i].data, vecs[i].pfx);
    end
    chk("pfx_err_pre", 32'(pfx_err), 32'd1);
    send(MZ, 15'h0000, 32'h0001_0000, 1'b1);
    send(MS, 15'h7FFF, 32'hFFFF_FFFF, 1'b0);
    idle(2);
    chk("pfx_err_sticky", 32'(pfx_err), 32'd1);

    // Back-pressure then release into back-to-back outputs
    out_ready = 1'b0;
    send(MZ, 15'h0011, 32'h0000_0011, 1'b0);
    in_valid = 1'b1;
    in_mode  = MZ;
    in_imm   = 15'h0022;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", out_data, 32'h0000_0011);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(MZ, 15'h0022, 32'h0000_0022, 1'b0);
    send(MZ, 15'h0033, 32'h0000_0033, 1'b0);
    idle(2);
    if (out_cyc.size() >= 3) begin
      int k;
      k = out_cyc.size();
      chk("no_bubble_a", 32'(out_cyc[k-2] - out_cyc[k-3]), 32'd1);
      chk("no_bubble_b", 32'(out_cyc[k-1] - out_cyc[k-2]), 32'd1);
    end else begin
      checks++;
      errors++;
      $display("FAIL bp_outputs: got %0d expected >=3", out_cyc.size());
    end

    // Flush discards an armed prefix
    send(MP, 15'h7FFF, 32'h0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    send(MS, 15'h0001, 32'h0000_0001, 1'b0);
    idle(2);

    // Reset while armed
    send(MP, 15'h1234, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_prefixed", 32'(out_prefixed), 32'd0);
    chk("arst_pfx_err", 32'(pfx_err), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send(MZ, 15'h0005, 32'h0000_0005, 1'b0);
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
